mem_arbiter: RTL

//  Shares one unified memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/arb_wdt.sv | 38 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-bus arbiter.
// State encodings are fixed so they line up with the pipeline debug taps.
package mem_arbiter_pkg;

    localparam int unsigned RegBusW      = 32;
    localparam int unsigned InstAddrBusW = 32;
    localparam logic [3:0]  SelAll       = 4'hF;

    typedef enum logic [1:0] {
        ArbIdle    = 2'b00,
        ArbIfBusy  = 2'b01,
        ArbMemBusy = 2'b10
    } arb_state_e;

    // Busy counter width: 8 bits covers the default limit, wider limits get 16.
    function automatic int unsigned wdt_cnt_w(input int unsigned timeout);
        return (timeout < 256) ? 8 : 16;
    endfunction

    function automatic logic is_busy(input arb_state_e st);
        return (st == ArbIfBusy) || (st == ArbMemBusy);
    endfunction

endpackage

// File: rtl/arb_wdt.sv
// Busy-cycle watchdog for mem_arbiter: counts cycles spent in a bus cycle and
// flags expiry when the count reaches TIMEOUT without a slave ack.
module arb_wdt
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expire
);

    localparam int unsigned CntW = wdt_cnt_w(TIMEOUT);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] count_q, count_d;

    assign expire = start & (count_q == Limit);

    // Count is 0 in the first busy cycle and clears as soon as the cycle ends.
    always_comb begin
        count_d = count_q + 1'b1;
        if (!start || ack || expire) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one memory bus between IF and MEM (MEM wins).
// Optional busy timeout with error abort when ARB_TIMEOUT_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = InstAddrBusW,
    parameter int unsigned DATA_W  = RegBusW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,

    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,

    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic              err_o
);

    arb_state_e state_q;
    logic       busy;
    logic       timeout;
    logic       done;

    assign busy = is_busy(state_q);

`ifdef ARB_TIMEOUT_EN
    logic wdt_expire;

    arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .start  (busy),
        .ack    (bus_ack_i),
        .expire (wdt_expire)
    );

    // A slave ack in the expiry cycle wins: normal completion, no error.
    assign timeout = wdt_expire & ~bus_ack_i;
`else
    assign timeout = 1'b0;
`endif

    assign done = busy & (bus_ack_i | timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ArbIdle;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'h0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            unique case (state_q)
                ArbIdle: begin
                    if (mem_req_i) begin
                        state_q     <= ArbMemBusy;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                    end else if (if_req_i) begin
                        state_q     <= ArbIfBusy;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= SelAll;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                    end else begin
                        bus_req_o   <= 1'b0;
                    end
                end
                ArbIfBusy, ArbMemBusy: begin
                    // Always return through IDLE so the requester can drop req.
                    if (done) begin
                        state_q   <= ArbIdle;
                        bus_req_o <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ArbIdle;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        if_ack_o    = 1'b0;
        if_rdata_o  = '0;
        mem_ack_o   = 1'b0;
        mem_rdata_o = '0;
        err_o       = 1'b0;
        if (done) begin
            err_o = timeout;
            if (state_q == ArbIfBusy) begin
                if_ack_o   = 1'b1;
                if_rdata_o = timeout ? '0 : bus_rdata_i;
            end else begin
                mem_ack_o   = 1'b1;
                mem_rdata_o = timeout ? '0 : bus_rdata_i;
            end
        end
    end

    assign stallreq_if_o  = if_req_i & ~if_ack_o;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

endmodule
